// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus width-generic
// two's-complement helpers for the iterative mul/div unit.
package muldiv_pkg;

  localparam int MAXW = 128;
  typedef logic [MAXW-1:0] word_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_FIN
  } state_e;

  // Callers zero-extend a w-bit value into word_t and keep the
  // low w bits of the result.
  function automatic word_t neg(input word_t x);
    return ~x + word_t'(1);
  endfunction

  function automatic word_t abs_w(input word_t x,
                                  input int unsigned w);
    return x[w-1] ? neg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU, WIDTH cycles + FIX.
// Ports: clk, reset (sync, high), start/op/a/b in; busy/done/div_zero/hi/lo out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_e            state_q;
  logic [1:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     acc_q;
  logic [WIDTH-1:0]  opnd_q;
  logic              sa_q;
  logic              sb_q;
  logic              busy_q;
  logic              done_q;
  logic              divz_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  logic              is_div_in;
  logic              sgn_in;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              run_div;

  always_comb begin
    is_div_in = 1'b0;
    sgn_in    = 1'b0;
    unique case (op)
      OP_MULT:  sgn_in = 1'b1;
      OP_MULTU: sgn_in = 1'b0;
      OP_DIV: begin
        is_div_in = 1'b1;
        sgn_in    = 1'b1;
      end
      OP_DIVU:  is_div_in = 1'b1;
    endcase
  end

  always_comb begin
    mag_a = a;
    mag_b = b;
    if (sgn_in) begin
      mag_a = WIDTH'(abs_w(word_t'(a), WIDTH));
      mag_b = WIDTH'(abs_w(word_t'(b), WIDTH));
    end
  end

  assign run_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Multiply: accumulator high half gains the multiplicand when
  // the LSB of the multiplier (low half) is 1, then shifts right.
  logic [WIDTH:0]  mul_sum;
  logic [AW-1:0]   mul_next;

  assign mul_sum  = acc_q[AW-1:WIDTH] + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1)
                             : (acc_q >> 1);

  // Divide: {rem, quo} shifts left; a non-negative trial
  // difference (top bit clear) is kept and sets the quotient LSB.
  logic [AW-1:0]   div_sh;
  logic [WIDTH:0]  div_tr;
  logic [AW-1:0]   div_next;

  assign div_sh   = {acc_q[AW-2:0], 1'b0};
  assign div_tr   = div_sh[AW-1:WIDTH] - {1'b0, opnd_q};
  assign div_next = div_tr[WIDTH] ? div_sh
                  : {div_tr, div_sh[WIDTH-1:1], 1'b1};

  // Sign fix-up; sa_q/sb_q are only ever set for signed ops.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod = acc_q[2*WIDTH-1:0];
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (sa_q ^ sb_q) begin
      prod = (2*WIDTH)'(neg(word_t'(acc_q[2*WIDTH-1:0])));
      quo  = WIDTH'(neg(word_t'(acc_q[WIDTH-1:0])));
    end
    if (sa_q) begin
      rem = WIDTH'(neg(word_t'(acc_q[2*WIDTH-1:WIDTH])));
    end
    fix_hi = run_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = run_div ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      divz_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          if (start) begin
            op_q   <= op;
            sa_q   <= sgn_in & a[WIDTH-1];
            sb_q   <= sgn_in & b[WIDTH-1];
            cnt_q  <= CW'(WIDTH);
            acc_q  <= {{(WIDTH+1){1'b0}},
                       (is_div_in ? mag_a : mag_b)};
            opnd_q <= is_div_in ? mag_b : mag_a;
            if (is_div_in && (b == '0)) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              divz_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= run_div ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_FIN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit
// against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ez);
    longint q, r, p;
    logic [63:0] u;
    ez = 1'b0;
    eh = mh;
    el = ml;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {eh, el} = p;
      end
      2'b01: begin
        u = {32'b0, x} * {32'b0, y};
        {eh, el} = u;
      end
      2'b10: begin
        if (y == 0) ez = 1'b1;
        else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          el = q[31:0];
          eh = r[31:0];
        end
      end
      default: begin
        if (y == 0) ez = 1'b1;
        else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // Issue one op on the 32-bit unit; ign_k > 0 pulses a bogus
  // start in that cycle of the run.
  task automatic op32(input logic [1:0] o,
                      input logic [31:0] x,
                      input logic [31:0] y,
                      input int ign_k,
                      input string tag);
    logic [31:0] eh, el;
    logic ez;
    int dk;
    bit hold_ok;
    model(o, x, y, eh, el, ez);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dk = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 40 && dk == 0; k++) begin
      if (done) dk = k;
      else begin
        if (busy !== !ez || hi !== mh || lo !== ml || div_zero)
          hold_ok = 1'b0;
        if (k == ign_k) begin
          op = 2'b11; a = 32'd5; b = 32'd0; start = 1'b1;
        end else start = 1'b0;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk({tag, "/lat"}, 64'(dk), ez ? 64'd1 : 64'd34);
    chk({tag, "/hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "/hi"}, 64'(hi), 64'(eh));
    chk({tag, "/lo"}, 64'(lo), 64'(el));
    chk({tag, "/dz"}, 64'(div_zero), 64'(ez));
    chk({tag, "/busy"}, 64'(busy), 64'd0);
    mh = eh;
    ml = el;
    @(posedge clk); #1;
    chk({tag, "/pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dk;
    int nd;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/dz", 64'(div_zero), 64'd0);
    chk("rst/hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    op32(2'b00, 32'd7, 32'hFFFF_FFFD, 0, "mult_7_m3");
    op32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_ff");
    op32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mult_m1");
    op32(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    op32(2'b11, 32'd100, 32'd7, 0, "divu_100_7");
    op32(2'b11, 32'h451, 32'h20, 0, "divu_setup");
    chk("setup/hi", 64'(hi), 64'h11);
    chk("setup/lo", 64'(lo), 64'h22);
    op32(2'b10, 32'd5, 32'd0, 0, "div_by0");
    op32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_minneg");
    op32(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5, "ign_start");

    // back-to-back issue in the done cycle on the 8-bit unit
    op8 = 2'b01; a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dk = 0;
    for (int k = 1; k <= 20 && dk == 0; k++) begin
      if (done8) dk = k;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("w8a/lat", 64'(dk), 64'd10);
    chk("w8a/lo", 64'(lo8), 64'd15);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dk = 0;
    for (int k = 1; k <= 20 && dk == 0; k++) begin
      if (done8) dk = k;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("w8b/lat", 64'(dk), 64'd10);
    chk("w8b/hi", 64'(hi8), 64'hFE);
    chk("w8b/lo", 64'(lo8), 64'h01);

    // reset in the middle of a MULT
    op = 2'b00; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst/busy", 64'(busy), 64'd0);
    chk("mrst/done", 64'(done), 64'd0);
    chk("mrst/dz", 64'(div_zero), 64'd0);
    chk("mrst/hilo", {hi, lo}, 64'd0);
    mh = '0;
    ml = '0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("mrst/quiet", 64'(nd), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = '0;
      else if ($urandom_range(0, 3) == 0) begin
        ry = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) ry = -ry;
      end
      if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
      op32(ro, rx, ry, 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
